// File: rtl/hazard_stall_ctrl_if.sv
// Decoder-side bundle for the hazard/stall scheduler: D/E/M hazard operands in, pipeline
// enables and flushes out. Signal names follow the pipeline's stage-suffix naming.
interface hazard_stall_ctrl_if;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [1:0]  TuseRs_D;
    logic [1:0]  TuseRt_D;
    logic [4:0]  A3_E;
    logic [2:0]  Tnew_E;
    logic [4:0]  A3_M;
    logic [2:0]  Tnew_M;
    logic        MdStart_E;
    logic        MdIsDiv_E;
    logic        MdUse_D;
    logic        Eret_D;
    logic        ExcReq;
    logic        Stall_FD;
    logic        Flush_FD;
    logic        Flush_DE;
    logic        MdBusy;
    logic [1:0]  State;
    logic [31:0] StallCount;

    modport slave (
        input  A1_D, A2_D, TuseRs_D, TuseRt_D, A3_E, Tnew_E, A3_M, Tnew_M,
        input  MdStart_E, MdIsDiv_E, MdUse_D, Eret_D, ExcReq,
        output Stall_FD, Flush_FD, Flush_DE, MdBusy, State, StallCount
    );

    modport master (
        output A1_D, A2_D, TuseRs_D, TuseRt_D, A3_E, Tnew_E, A3_M, Tnew_M,
        output MdStart_E, MdIsDiv_E, MdUse_D, Eret_D, ExcReq,
        input  Stall_FD, Flush_FD, Flush_DE, MdBusy, State, StallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Five-stage pipeline stall/flush scheduler: Tuse/Tnew register hazards, mult/div busy
// countdown, exception/eret flush ordering. Define STALL_CNT_EN to get a stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_EXC = 2'd1;

    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_md;
    logic             w_stall;
    logic             w_in_exc;
    logic             w_md_busy;
    logic             w_stall_fd;
    logic             w_flush_fd;
    logic             w_flush_de;

    // Producer still further from ready than the consumer can tolerate; equal means forward.
    assign w_stall_rs = (bus.A1_D != 5'd0) &&
                        (((bus.A1_D == bus.A3_E) && (bus.Tnew_E > {1'b0, bus.TuseRs_D})) ||
                         ((bus.A1_D == bus.A3_M) && (bus.Tnew_M > {1'b0, bus.TuseRs_D})));

    assign w_stall_rt = (bus.A2_D != 5'd0) &&
                        (((bus.A2_D == bus.A3_E) && (bus.Tnew_E > {1'b0, bus.TuseRt_D})) ||
                         ((bus.A2_D == bus.A3_M) && (bus.Tnew_M > {1'b0, bus.TuseRt_D})));

    assign w_md_busy  = (r_count != '0);
    assign w_stall_md = bus.MdUse_D && (w_md_busy || bus.MdStart_E);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    // Encodings 2 and 3 are unreachable and behave as RUN.
    assign w_in_exc   = (r_state == ST_EXC);

    // NOTE: non-blocking assignments for all flop state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (bus.MdStart_E) begin
            r_count <= bus.MdIsDiv_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (w_md_busy) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= bus.ExcReq ? ST_EXC : ST_RUN;
        end
    end

    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    always_comb begin
        w_stall_fd = 1'b0;
        w_flush_fd = 1'b0;
        w_flush_de = 1'b0;
        if (reset) begin
            w_stall_fd = 1'b0;
        end else if (bus.ExcReq || w_in_exc) begin
            w_flush_fd = 1'b1;
            w_flush_de = 1'b1;
        end else if (w_stall) begin
            w_stall_fd = 1'b1;
            w_flush_de = 1'b1;
        end else if (bus.Eret_D) begin
            w_flush_fd = 1'b1;
        end
    end

    assign bus.Stall_FD = w_stall_fd;
    assign bus.Flush_FD = w_flush_fd;
    assign bus.Flush_DE = w_flush_de;
    assign bus.MdBusy   = w_md_busy;
    assign bus.State    = r_state;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 32'h0;
        end else if (w_stall_fd) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.StallCount = r_stall_count;
`else
    assign bus.StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; honours STALL_CNT_EN for the counter checks.
module tb_hazard_stall_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STALL_CNT_EN
    localparam logic [31:0] EXP_CNT4 = 32'd4;
`else
    localparam logic [31:0] EXP_CNT4 = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.A1_D      = 5'd0;
        bus.A2_D      = 5'd0;
        bus.TuseRs_D  = 2'd3;
        bus.TuseRt_D  = 2'd3;
        bus.A3_E      = 5'd0;
        bus.Tnew_E    = 3'd0;
        bus.A3_M      = 5'd0;
        bus.Tnew_M    = 3'd0;
        bus.MdStart_E = 1'b0;
        bus.MdIsDiv_E = 1'b0;
        bus.MdUse_D   = 1'b0;
        bus.Eret_D    = 1'b0;
        bus.ExcReq    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic stall, input logic ffd, input logic fde);
        check({tag, ".stall"}, 32'(bus.Stall_FD), 32'(stall));
        check({tag, ".ffd"},   32'(bus.Flush_FD), 32'(ffd));
        check({tag, ".fde"},   32'(bus.Flush_DE), 32'(fde));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check("rst.busy",  32'(bus.MdBusy), 32'd0);
        check("rst.state", 32'(bus.State), 32'd0);
        check("rst.cnt",   bus.StallCount, 32'd0);
        reset = 1'b0;

        // rs hazard on E (Tnew 1 > Tuse 0), then producer at M ready (forward)
        next_cycle();
        bus.A1_D = 5'd5; bus.TuseRs_D = 2'd0; bus.A3_E = 5'd5; bus.Tnew_E = 3'd1;
        @(negedge clk);
        check_ctl("rs_e", 1'b1, 1'b0, 1'b1);
        next_cycle();
        bus.A3_E = 5'd0; bus.Tnew_E = 3'd0; bus.A3_M = 5'd5; bus.Tnew_M = 3'd0;
        @(negedge clk);
        check_ctl("rs_m_fwd", 1'b0, 1'b0, 1'b0);

        // $0 never stalls
        next_cycle();
        idle_inputs();
        bus.A1_D = 5'd0; bus.A3_E = 5'd0; bus.Tnew_E = 3'd2; bus.TuseRs_D = 2'd0;
        @(negedge clk);
        check("r0", 32'(bus.Stall_FD), 32'd0);

        // rt: equal Tnew/Tuse forwards, larger Tnew stalls, M-stage too
        next_cycle();
        idle_inputs();
        bus.A2_D = 5'd7; bus.TuseRt_D = 2'd1; bus.A3_E = 5'd7; bus.Tnew_E = 3'd1;
        @(negedge clk);
        check("rt_eq", 32'(bus.Stall_FD), 32'd0);
        next_cycle();
        bus.Tnew_E = 3'd2;
        @(negedge clk);
        check("rt_e", 32'(bus.Stall_FD), 32'd1);
        next_cycle();
        bus.A3_E = 5'd0; bus.A3_M = 5'd7; bus.Tnew_M = 3'd2;
        @(negedge clk);
        check("rt_m", 32'(bus.Stall_FD), 32'd1);

        // eret alone drops slot; eret under stall is ignored
        next_cycle();
        idle_inputs();
        bus.Eret_D = 1'b1;
        @(negedge clk);
        check_ctl("eret", 1'b0, 1'b1, 1'b0);
        next_cycle();
        bus.A1_D = 5'd9; bus.TuseRs_D = 2'd0; bus.A3_E = 5'd9; bus.Tnew_E = 3'd2;
        @(negedge clk);
        check_ctl("eret_stall", 1'b1, 1'b0, 1'b1);

        // div issue with MdUse_D held: 11 stalled cycles, busy exactly 10
        next_cycle();
        idle_inputs();
        bus.MdStart_E = 1'b1; bus.MdIsDiv_E = 1'b1; bus.MdUse_D = 1'b1;
        @(negedge clk);
        check("div0.stall", 32'(bus.Stall_FD), 32'd1);
        check("div0.busy",  32'(bus.MdBusy), 32'd0);
        next_cycle();
        bus.MdStart_E = 1'b0; bus.MdIsDiv_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("div%0d.busy", i), 32'(bus.MdBusy), 32'd1);
            check($sformatf("div%0d.stall", i), 32'(bus.Stall_FD), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check("div_end.busy",  32'(bus.MdBusy), 32'd0);
        check("div_end.stall", 32'(bus.Stall_FD), 32'd0);

        // Exception overrides an ongoing stall, holds one extra cycle in EXC
        next_cycle();
        idle_inputs();
        bus.A1_D = 5'd3; bus.A3_E = 5'd3; bus.Tnew_E = 3'd2; bus.TuseRs_D = 2'd0;
        @(negedge clk);
        check_ctl("exc_pre", 1'b1, 1'b0, 1'b1);
        next_cycle();
        bus.ExcReq = 1'b1;
        @(negedge clk);
        check_ctl("exc0", 1'b0, 1'b1, 1'b1);
        check("exc0.state", 32'(bus.State), 32'd0);
        next_cycle();
        bus.ExcReq = 1'b0;
        @(negedge clk);
        check_ctl("exc1", 1'b0, 1'b1, 1'b1);
        check("exc1.state", 32'(bus.State), 32'd1);
        next_cycle();
        @(negedge clk);
        check("exc2.state", 32'(bus.State), 32'd0);
        check_ctl("exc2", 1'b1, 1'b0, 1'b1);

        // Async reset mid-mult at count=3
        next_cycle();
        idle_inputs();
        bus.MdStart_E = 1'b1;
        next_cycle();
        bus.MdStart_E = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("mult.busy", 32'(bus.MdBusy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst.busy",  32'(bus.MdBusy), 32'd0);
        check_ctl("arst", 1'b0, 1'b0, 1'b0);
        check("arst.state", 32'(bus.State), 32'd0);
        check("arst.cnt",   bus.StallCount, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst.busy", 32'(bus.MdBusy), 32'd0);

        // Four stalled cycles, then reset clears the counter
        next_cycle();
        bus.A1_D = 5'd4; bus.TuseRs_D = 2'd0; bus.A3_E = 5'd4; bus.Tnew_E = 3'd1;
        repeat (4) @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("cnt4", bus.StallCount, EXP_CNT4);
        reset = 1'b1;
        #1;
        check("cnt_rst", bus.StallCount, 32'd0);
        next_cycle();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
